// File: rtl/hvgen_param_if.sv
// Video timing bus between the raster generator, the game core and the output path.
// The master side is the timing generator; the slave side is the core/video consumer.
interface hvgen_param_if #(
   parameter int OFS_W = 5,
   parameter int RGB_W = 8
);
   logic             PCE;
   logic [OFS_W-1:0] HOFFS;
   logic [OFS_W-1:0] VOFFS;
   logic [RGB_W-1:0] iRGB;
   logic [8:0]       HPOS;
   logic [8:0]       VPOS;
   logic [RGB_W-1:0] oRGB;
   logic             HBLK;
   logic             VBLK;
   logic             HSYN;
   logic             VSYN;
   logic             DE;
   logic             FRAME;

   modport master (
      input  PCE, HOFFS, VOFFS, iRGB,
      output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, FRAME
   );

   modport slave (
      output PCE, HOFFS, VOFFS, iRGB,
      input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE, FRAME
   );
endinterface

// File: rtl/hvgen_param.sv
// Parametrised raster timing generator: pixel/line counters, registered blank/sync/DE
// decode one pixel behind HPOS/VPOS, blank-gated RGB, frame-latched clamped sync offsets
// and a one-MCLK frame-start strobe. Everything advances only on the pixel clock enable.
module hvgen_param #(
   parameter int H_TOTAL  = 456,
   parameter int H_ACTIVE = 336,
   parameter int HS_START = 360,
   parameter int HS_WIDTH = 24,
   parameter int V_TOTAL  = 262,
   parameter int V_ACTIVE = 240,
   parameter int VS_START = 240,
   parameter int VS_WIDTH = 3,
   parameter int OFS_W    = 5,
   parameter int OFS_STEP = 2,
   parameter int RGB_W    = 8
) (
   input  logic          MCLK,
   input  logic          RESET,
   hvgen_param_if.master bus
);

   // Reject geometries where sync cannot fit in the blanking interval or counters overflow.
   if (!(H_ACTIVE < H_TOTAL) || !(HS_WIDTH < H_TOTAL - H_ACTIVE) ||
       !(V_ACTIVE < V_TOTAL) || !(VS_WIDTH < V_TOTAL - V_ACTIVE) ||
       (H_TOTAL > 512) || (V_TOTAL > 512)) begin : g_param_check
      $error("hvgen_param: illegal timing parameters");
   end

   localparam logic signed [10:0] HS_START_S = 11'(HS_START);
   localparam logic signed [10:0] VS_START_S = 11'(VS_START);
   localparam logic signed [10:0] STEP_S     = 11'(OFS_STEP);
   localparam logic signed [10:0] HS_MIN_S   = 11'(H_ACTIVE);
   localparam logic signed [10:0] HS_MAX_S   = 11'(H_TOTAL - HS_WIDTH);
   localparam logic signed [10:0] VS_MIN_S   = 11'(V_ACTIVE);
   localparam logic signed [10:0] VS_MAX_S   = 11'(V_TOTAL - VS_WIDTH);

   // Keeps the sync start inside the blanking interval so it never overlaps video or wraps.
   function automatic logic [8:0] clamp_pos(input logic signed [10:0] raw,
                                            input logic signed [10:0] lo,
                                            input logic signed [10:0] hi);
      logic signed [10:0] c;
      c = raw;
      if (raw < lo) begin
         c = lo;
      end else if (raw > hi) begin
         c = hi;
      end
      return c[8:0];
   endfunction

   logic [8:0]       hcnt_q, hcnt_d;
   logic [8:0]       vcnt_q, vcnt_d;
   logic [8:0]       hs_b_q, hs_b_d;
   logic [8:0]       vs_b_q, vs_b_d;
   logic             hblk_q, hblk_d;
   logic             vblk_q, vblk_d;
   logic             hsyn_q, hsyn_d;
   logic             vsyn_q, vsyn_d;
   logic             de_q, de_d;
   logic             frame_q;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic             h_last, v_last, frame_end, blank_d;
   logic signed [10:0] hofs_sx, vofs_sx, hs_raw, vs_raw;

   assign h_last    = (hcnt_q == 9'(H_TOTAL - 1));
   assign v_last    = (vcnt_q == 9'(V_TOTAL - 1));
   assign frame_end = h_last & v_last;

   // Sign-extend the offsets and scale them into pixel/line units.
   assign hofs_sx = {{(11 - OFS_W){bus.HOFFS[OFS_W-1]}}, bus.HOFFS};
   assign vofs_sx = {{(11 - OFS_W){bus.VOFFS[OFS_W-1]}}, bus.VOFFS};
   assign hs_raw  = HS_START_S + hofs_sx * STEP_S;
   assign vs_raw  = VS_START_S + vofs_sx * STEP_S;
   assign hs_b_d  = clamp_pos(hs_raw, HS_MIN_S, HS_MAX_S);
   assign vs_b_d  = clamp_pos(vs_raw, VS_MIN_S, VS_MAX_S);

   // Next pixel/line position: fixed-length lines, line counter steps on each line wrap.
   always_comb begin
      hcnt_d = hcnt_q + 9'd1;
      vcnt_d = vcnt_q;
      if (h_last) begin
         hcnt_d = '0;
         vcnt_d = v_last ? 9'd0 : vcnt_q + 9'd1;
      end
   end

   // Blank/sync/DE decode of the current (pre-increment) position.
   always_comb begin
      hblk_d  = (hcnt_q >= 9'(H_ACTIVE));
      vblk_d  = (vcnt_q >= 9'(V_ACTIVE));
      hsyn_d  = ~((hcnt_q >= hs_b_q) &&
                  ({1'b0, hcnt_q} < ({1'b0, hs_b_q} + 10'(HS_WIDTH))));
      vsyn_d  = ~((vcnt_q >= vs_b_q) &&
                  ({1'b0, vcnt_q} < ({1'b0, vs_b_q} + 10'(VS_WIDTH))));
      blank_d = hblk_d | vblk_d;
      de_d    = ~blank_d;
   end

   for (genvar gi = 0; gi < RGB_W; gi++) begin : g_rgb_gate
      assign rgb_d[gi] = bus.iRGB[gi] & ~blank_d;
   end

   // Counter and offset-latch state; offsets only change across the frame wrap.
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
         hs_b_q <= 9'(HS_START);
         vs_b_q <= 9'(VS_START);
      end else if (bus.PCE) begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         if (frame_end) begin
            hs_b_q <= hs_b_d;
            vs_b_q <= vs_b_d;
         end
      end
   end

   // Registered video outputs plus the single-MCLK frame-start strobe.
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         hblk_q  <= 1'b1;
         vblk_q  <= 1'b1;
         hsyn_q  <= 1'b1;
         vsyn_q  <= 1'b1;
         de_q    <= 1'b0;
         rgb_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         frame_q <= bus.PCE & frame_end;
         if (bus.PCE) begin
            hblk_q <= hblk_d;
            vblk_q <= vblk_d;
            hsyn_q <= hsyn_d;
            vsyn_q <= vsyn_d;
            de_q   <= de_d;
            rgb_q  <= rgb_d;
         end
      end
   end

   assign bus.HPOS  = hcnt_q;
   assign bus.VPOS  = vcnt_q;
   assign bus.HBLK  = hblk_q;
   assign bus.VBLK  = vblk_q;
   assign bus.HSYN  = hsyn_q;
   assign bus.VSYN  = vsyn_q;
   assign bus.DE    = de_q;
   assign bus.oRGB  = rgb_q;
   assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_hvgen_param.sv
// Directed bench for hvgen_param: default horizontal geometry, shortened frame height
// so whole frames fit in a short run.
module tb_hvgen_param;
   localparam int H_TOTAL  = 456;
   localparam int H_ACTIVE = 336;
   localparam int HS_START = 360;
   localparam int HS_WIDTH = 24;
   localparam int V_TOTAL  = 12;
   localparam int V_ACTIVE = 8;
   localparam int VS_START = 8;
   localparam int VS_WIDTH = 3;
   localparam int OFS_W    = 5;
   localparam int OFS_STEP = 2;
   localparam int RGB_W    = 8;

   logic MCLK = 1'b0;
   logic RESET;
   int   n_checks = 0;
   int   n_fail = 0;
   int   frame_seen = 0;

   hvgen_param_if #(.OFS_W(OFS_W), .RGB_W(RGB_W)) bus ();

   hvgen_param #(
      .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START), .HS_WIDTH(HS_WIDTH),
      .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH),
      .OFS_W(OFS_W), .OFS_STEP(OFS_STEP), .RGB_W(RGB_W)
   ) dut (
      .MCLK(MCLK),
      .RESET(RESET),
      .bus(bus)
   );

   always #5 MCLK = ~MCLK;

   // One pixel: a PCE edge followed by gap idle MCLK edges; FRAME sampled on every edge.
   task automatic pix(input int gap);
      bus.PCE = 1'b1;
      @(posedge MCLK); #1;
      if (bus.FRAME === 1'b1) frame_seen++;
      bus.PCE = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(posedge MCLK); #1;
         if (bus.FRAME === 1'b1) frame_seen++;
      end
   endtask

   task automatic goto_pos(input int h, input int v, input int gap);
      int n;
      n = 0;
      do begin
         pix(gap);
         n++;
      end while (!(bus.HPOS == 9'(h) && bus.VPOS == 9'(v)) && n < H_TOTAL * V_TOTAL + 4);
      n_checks++;
      if (bus.HPOS !== 9'(h) || bus.VPOS !== 9'(v)) begin
         n_fail++;
         $display("FAIL goto: reached (%0d,%0d) required (%0d,%0d)", bus.HPOS, bus.VPOS, h, v);
      end
   endtask

   // Scans one line from HPOS=0; reports the first HPOS with HSYN low and the low count.
   task automatic scan_line(output int hs_first, output int hs_cnt);
      hs_first = -1;
      hs_cnt   = 0;
      for (int i = 0; i < H_TOTAL; i++) begin
         pix(0);
         if (bus.HSYN === 1'b0) begin
            if (hs_first < 0) hs_first = int'(bus.HPOS);
            hs_cnt++;
         end
      end
   endtask

   // Scans one whole frame from (0,0) with iRGB=FF; loop indices are the decoded position.
   task automatic scan_frame(output int hs_first, output int hs_cnt,
                             output logic [V_TOTAL-1:0] vs_mask, output int vs_cnt,
                             output int de_cnt, output int frames, output int dec_err);
      logic            exp_hb, exp_vb;
      logic [RGB_W-1:0] exp_rgb;
      hs_first = -1; hs_cnt = 0; vs_mask = '0; vs_cnt = 0; de_cnt = 0; dec_err = 0;
      frame_seen = 0;
      for (int v = 0; v < V_TOTAL; v++) begin
         for (int h = 0; h < H_TOTAL; h++) begin
            pix(0);
            exp_hb  = (h >= H_ACTIVE);
            exp_vb  = (v >= V_ACTIVE);
            exp_rgb = (exp_hb || exp_vb) ? 8'h00 : 8'hFF;
            if (bus.HBLK !== exp_hb || bus.VBLK !== exp_vb || bus.DE !== !(exp_hb || exp_vb) ||
                bus.oRGB !== exp_rgb || bus.HPOS !== 9'((h + 1) % H_TOTAL)) dec_err++;
            if (bus.DE === 1'b1) de_cnt++;
            if (bus.VSYN === 1'b0) vs_cnt++;
            if (h == 0) vs_mask[v] = (bus.VSYN === 1'b0);
            if (v == 0 && bus.HSYN === 1'b0) begin
               if (hs_first < 0) hs_first = int'(bus.HPOS);
               hs_cnt++;
            end
         end
      end
      frames = frame_seen;
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      bus.PCE = 1'b1; bus.HOFFS = '0; bus.VOFFS = '0; bus.iRGB = 8'hA5;
      RESET = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge MCLK); #1;
         obs = {bus.HPOS, bus.VPOS, bus.HBLK, bus.VBLK, bus.HSYN, bus.VSYN, bus.DE,
                bus.oRGB, bus.FRAME};
         n_checks++;
         if (obs !== {9'd0, 9'd0, 5'b11110, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got %h required %h", c, obs,
                     {9'd0, 9'd0, 5'b11110, 8'h00, 1'b0});
         end
      end
      RESET = 1'b0; bus.PCE = 1'b0;
      @(posedge MCLK); #1;
      n_checks++;
      if (bus.HPOS !== 9'd0 || bus.HBLK !== 1'b1 || bus.DE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_nopce: HPOS=%0d HBLK=%b DE=%b required 0 1 0", bus.HPOS, bus.HBLK, bus.DE);
      end
      pix(3);
      n_checks++;
      if (bus.HPOS !== 9'd1 || bus.VPOS !== 9'd0 || bus.HBLK !== 1'b0 || bus.VBLK !== 1'b0 ||
          bus.DE !== 1'b1 || bus.HSYN !== 1'b1 || bus.oRGB !== 8'hA5) begin
         n_fail++;
         $display("FAIL first_pce: HPOS=%0d VPOS=%0d HBLK=%b VBLK=%b DE=%b HSYN=%b oRGB=%h required 1 0 0 0 1 1 a5",
                  bus.HPOS, bus.VPOS, bus.HBLK, bus.VBLK, bus.DE, bus.HSYN, bus.oRGB);
      end
      $display("test_reset done");
   endtask

   task automatic test_line_timing();
      int n;
      goto_pos(336, 0, 3);
      n_checks++;
      if (bus.HBLK !== 1'b0 || bus.oRGB !== 8'hA5) begin
         n_fail++;
         $display("FAIL hblk_h335: HBLK=%b oRGB=%h required 0 a5", bus.HBLK, bus.oRGB);
      end
      pix(3);
      n_checks++;
      if (bus.HBLK !== 1'b1 || bus.DE !== 1'b0 || bus.oRGB !== 8'h00) begin
         n_fail++;
         $display("FAIL hblk_h336: HBLK=%b DE=%b oRGB=%h required 1 0 00", bus.HBLK, bus.DE, bus.oRGB);
      end
      n = 0;
      do begin
         pix(3);
         n++;
      end while (bus.HPOS != 9'd337 && n < 1000);
      n_checks++;
      if (n != H_TOTAL || bus.VPOS !== 9'd1) begin
         n_fail++;
         $display("FAIL line_period: %0d PCE to VPOS=%0d, required 456 to VPOS=1", n, bus.VPOS);
      end
      $display("test_line_timing done, line period %0d", n);
   endtask

   task automatic test_sync_default();
      int hs_first, hs_cnt, vs_cnt, de_cnt, frames, dec_err;
      logic [V_TOTAL-1:0] vs_mask;
      bus.iRGB = 8'hFF;
      goto_pos(0, 0, 0);
      n_checks++;
      if (bus.FRAME !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_after_wrap: FRAME=%b required 1", bus.FRAME);
      end
      scan_frame(hs_first, hs_cnt, vs_mask, vs_cnt, de_cnt, frames, dec_err);
      n_checks++;
      if (hs_first != HS_START + 1 || hs_cnt != HS_WIDTH) begin
         n_fail++;
         $display("FAIL hsync_default: first=%0d len=%0d required 361 24", hs_first, hs_cnt);
      end
      n_checks++;
      if (vs_mask !== 12'b0111_0000_0000 || vs_cnt != VS_WIDTH * H_TOTAL) begin
         n_fail++;
         $display("FAIL vsync_default: mask=%b cnt=%0d required 011100000000 1368", vs_mask, vs_cnt);
      end
      n_checks++;
      if (de_cnt != H_ACTIVE * V_ACTIVE) begin
         n_fail++;
         $display("FAIL de_count: got %0d required %0d", de_cnt, H_ACTIVE * V_ACTIVE);
      end
      n_checks++;
      if (frames != 1) begin
         n_fail++;
         $display("FAIL frame_count: got %0d required 1", frames);
      end
      n_checks++;
      if (dec_err != 0) begin
         n_fail++;
         $display("FAIL blank_gating: %0d bad pixels required 0", dec_err);
      end
      $display("test_sync_default done, hs %0d/%0d de %0d", hs_first, hs_cnt, de_cnt);
   endtask

   task automatic test_offset_clamp();
      int hs_first, hs_cnt, vs_cnt, de_cnt, frames, dec_err;
      logic [V_TOTAL-1:0] vs_mask;
      bus.HOFFS = 5'b10000;
      goto_pos(0, 0, 0);
      scan_line(hs_first, hs_cnt);
      n_checks++;
      if (hs_first != 337 || hs_cnt != HS_WIDTH) begin
         n_fail++;
         $display("FAIL hoffs_m16: first=%0d len=%0d required 337 24", hs_first, hs_cnt);
      end
      bus.HOFFS = 5'd15;
      goto_pos(0, 0, 0);
      scan_line(hs_first, hs_cnt);
      n_checks++;
      if (hs_first != 391 || hs_cnt != HS_WIDTH) begin
         n_fail++;
         $display("FAIL hoffs_p15: first=%0d len=%0d required 391 24", hs_first, hs_cnt);
      end
      bus.HOFFS = '0;
      bus.VOFFS = 5'd15;
      goto_pos(0, 0, 0);
      scan_frame(hs_first, hs_cnt, vs_mask, vs_cnt, de_cnt, frames, dec_err);
      n_checks++;
      if (vs_mask !== 12'b1110_0000_0000 || vs_cnt != VS_WIDTH * H_TOTAL || hs_first != 361) begin
         n_fail++;
         $display("FAIL voffs_p15: mask=%b cnt=%0d hs=%0d required 111000000000 1368 361",
                  vs_mask, vs_cnt, hs_first);
      end
      bus.VOFFS = '0;
      $display("test_offset_clamp done");
   endtask

   task automatic test_midframe_offset();
      int hs_first, hs_cnt;
      bus.HOFFS = '0;
      goto_pos(0, 0, 0);
      goto_pos(0, 4, 0);
      bus.HOFFS = 5'd5;
      scan_line(hs_first, hs_cnt);
      n_checks++;
      if (hs_first != 361) begin
         n_fail++;
         $display("FAIL midframe_line4: first=%0d required 361", hs_first);
      end
      goto_pos(0, 11, 0);
      scan_line(hs_first, hs_cnt);
      n_checks++;
      if (hs_first != 361) begin
         n_fail++;
         $display("FAIL midframe_last_line: first=%0d required 361", hs_first);
      end
      scan_line(hs_first, hs_cnt);
      n_checks++;
      if (hs_first != 371 || hs_cnt != HS_WIDTH) begin
         n_fail++;
         $display("FAIL midframe_next_frame: first=%0d len=%0d required 371 24", hs_first, hs_cnt);
      end
      $display("test_midframe_offset done");
   endtask

   task automatic test_freeze();
      logic [31:0] snap, obs;
      int          diff;
      goto_pos(200, 3, 0);
      snap = {bus.HPOS, bus.VPOS, bus.HBLK, bus.VBLK, bus.HSYN, bus.VSYN, bus.DE,
              bus.oRGB, bus.FRAME};
      bus.iRGB = 8'h3C;
      diff = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge MCLK); #1;
         obs = {bus.HPOS, bus.VPOS, bus.HBLK, bus.VBLK, bus.HSYN, bus.VSYN, bus.DE,
                bus.oRGB, bus.FRAME};
         if (obs !== snap) diff++;
      end
      n_checks++;
      if (diff != 0) begin
         n_fail++;
         $display("FAIL freeze: %0d changed cycles required 0", diff);
      end
      bus.iRGB = 8'hFF;
      pix(3);
      n_checks++;
      if (bus.HPOS !== 9'd201 || bus.oRGB !== 8'hFF) begin
         n_fail++;
         $display("FAIL resume: HPOS=%0d oRGB=%h required 201 ff", bus.HPOS, bus.oRGB);
      end
      $display("test_freeze done");
   endtask

   task automatic test_reset_midframe();
      int hs_first, hs_cnt, fr;
      goto_pos(200, 5, 0);
      bus.HOFFS = 5'd15;
      RESET = 1'b1; bus.PCE = 1'b1;
      @(posedge MCLK); #1;
      fr = (bus.FRAME === 1'b1) ? 1 : 0;
      n_checks++;
      if (bus.HPOS !== 9'd0 || bus.VPOS !== 9'd0 || bus.HBLK !== 1'b1 || bus.VBLK !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: HPOS=%0d VPOS=%0d HBLK=%b VBLK=%b required 0 0 1 1",
                  bus.HPOS, bus.VPOS, bus.HBLK, bus.VBLK);
      end
      RESET = 1'b0; bus.PCE = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge MCLK); #1;
         if (bus.FRAME === 1'b1) fr++;
      end
      n_checks++;
      if (fr != 0) begin
         n_fail++;
         $display("FAIL reset_no_frame: %0d FRAME pulses required 0", fr);
      end
      scan_line(hs_first, hs_cnt);
      n_checks++;
      if (hs_first != 361 || bus.VPOS !== 9'd1) begin
         n_fail++;
         $display("FAIL reset_offset: first=%0d VPOS=%0d required 361 1", hs_first, bus.VPOS);
      end
      $display("test_reset_midframe done");
   endtask

   initial begin
      RESET = 1'b1;
      bus.PCE = 1'b0; bus.HOFFS = '0; bus.VOFFS = '0; bus.iRGB = '0;
      test_reset();
      test_line_timing();
      test_sync_default();
      test_offset_clamp();
      test_midframe_offset();
      test_freeze();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hvgen_param.md
Name: hvgen_param

Overview:
- Parametrised raster timing generator; successor to the fixed-geometry H/V generator used by the arcade cores.
- Runs on a single system clock with a pixel clock-enable, not a derived pixel clock.
- Generates pixel/line counters, blanking, syncs and DE, and gates RGB data with an output width set by parameter.
- Adds signed H/V sync offsets that are clamped and latched once per frame, plus a frame-start strobe. The block sits between the game core (which consumes HPOS/VPOS and supplies RGB) and the video output/scaler path.

Parameters:
- H_TOTAL, 456, pixels per line (counter wraps at H_TOTAL-1)
- H_ACTIVE, 336, visible pixels per line
- HS_START, 360, nominal HSYNC start pixel
- HS_WIDTH, 24, HSYNC width in pixels
- V_TOTAL, 262, lines per frame
- V_ACTIVE, 240, visible lines
- VS_START, 240, nominal VSYNC start line
- VS_WIDTH, 3, VSYNC width in lines
- OFS_W, 5, width of signed offset inputs
- OFS_STEP, 2, pixels/lines moved per offset LSB
- RGB_W, 8, colour bus width

Ports:
- MCLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- PCE  in  1  pixel clock enable; all state advances only when PCE=1
- HOFFS  in  OFS_W  signed two's-complement HSYNC offset
- VOFFS  in  OFS_W  signed two's-complement VSYNC offset
- iRGB  in  RGB_W  pixel data from core, sampled on PCE
- HPOS  out  9  current pixel counter (combinational from hcnt)
- VPOS  out  9  current line counter (combinational from vcnt)
- oRGB  out  RGB_W  registered, blank-gated pixel
- HBLK  out  1  horizontal blank, registered
- VBLK  out  1  vertical blank, registered
- HSYN  out  1  active-low HSYNC, registered
- VSYN  out  1  active-low VSYNC, registered
- DE  out  1  registered ~(HBLK|VBLK)
- FRAME  out  1  one-MCLK strobe at frame start

Behaviour:
- Reset: the clock is MCLK and RESET is synchronous and active-high (decided). While RESET=1, at each MCLK edge:
  - hcnt=0, vcnt=0
  - HBLK=1, VBLK=1, HSYN=1, VSYN=1, DE=0, oRGB=0, FRAME=0
  - latched offsets = 0, so hs_b=HS_START and vs_b=VS_START
  - RESET overrides PCE. Reset mid-frame restarts at (0,0) on the first PCE after release.
- Counters, on an MCLK edge with PCE=1:
  - hcnt increments; when hcnt==H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps to 0 after V_TOTAL-1.
  - No skip or jump of hcnt, so line length is always exactly H_TOTAL regardless of offset.
- Registered decode, on a PCE edge, using the pre-increment counters (h,v); this gives exactly one PCE of latency relative to HPOS/VPOS:
  - HBLK <= (h >= H_ACTIVE)
  - VBLK <= (v >= V_ACTIVE)
  - HSYN <= ~(h >= hs_b && h < hs_b+HS_WIDTH)
  - VSYN <= ~(v >= vs_b && v < vs_b+VS_WIDTH)
  - DE <= ~(HBLK_next | VBLK_next)
  - oRGB <= blank_next ? 0 : iRGB
- Without PCE, all outputs hold.
- Offset arithmetic:
  - hs_raw = HS_START + sext(HOFFS)*OFS_STEP, in 11-bit signed arithmetic.
  - hs_b = clamp(hs_raw, H_ACTIVE, H_TOTAL-HS_WIDTH).
  - vs_b is computed the same way from VS_START/VOFFS and clamped to [V_ACTIVE, V_TOTAL-VS_WIDTH].
  - Clamping guarantees sync never overlaps active video and never wraps past the line/frame end.
- Offset latch: hs_b/vs_b register only on the PCE edge where h==H_TOTAL-1 and v==V_TOTAL-1. Offset changes mid-frame take effect at the next frame, giving no torn sync pulses.
- FRAME: high for exactly one MCLK cycle, on the edge after the PCE edge that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0). It is low otherwise, including when PCE is held high continuously.
- Elaboration check: parameter sanity (H_ACTIVE < H_TOTAL, HS_WIDTH < H_TOTAL-H_ACTIVE, same for V; all totals <= 512) is enforced with an elaboration-time error.

Test Plan:
- Defaults, PCE every 4th MCLK, reset 3 cycles:
  - outputs hold reset values during reset.
  - after release, the first PCE gives HPOS=1 and HBLK=0; HBLK rises when the decode of h=336 registers.
  - line period = 456 PCE; frame = 262 lines.
- Sync placement, HOFFS=0, VOFFS=0:
  - HSYN low for exactly 24 PCE, starting with the decode of h=360.
  - VSYN low for lines 240..242.
  - DE high exactly 336×240 PCE per frame.
- Offset clamp:
  - HOFFS=-16 gives raw 328, clamped to 336.
  - HOFFS=+15 gives 390.
  - VOFFS=+15 gives raw 270, clamped to 259; VSYN covers lines 259..261.
- Mid-frame offset change: HOFFS changes 0→+5 at line 100. Line 100..261 HSYN still starts at 360; from next frame line 0 it starts at 370.
- Blank gating: iRGB=8'hFF constant gives oRGB=0 whenever HBLK|VBLK, and FF otherwise. PCE held low 50 cycles mid-line gives all outputs frozen.
- FRAME and reset:
  - exactly one 1-cycle FRAME per frame.
  - RESET asserted at h=200, v=120 for 1 cycle: counters return to 0, HBLK=VBLK=1, no FRAME pulse from the reset itself.
